// File: rtl/i2s_xmit_pkg.sv
// ---------------------------------------------------------------------------
// i2s_xmit_pkg
// Shared definitions for the I2S transmit path (and its receive twin):
//   - default sample width, slot length and mck->bck divider
//   - lrck channel encoding (0 = left slot, 1 = right slot)
//   - small helpers for frame geometry
// ---------------------------------------------------------------------------
package i2s_xmit_pkg;

    localparam int I2S_WIDTH   = 24;   // sample width in bits
    localparam int I2S_SLOT    = 32;   // bck periods per channel slot
    localparam int I2S_BCK_DIV = 4;    // mck cycles per bck period

    // lrck level identifies the channel currently being shifted out.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    // Number of mck cycles in one full left+right frame.
    function automatic int unsigned frame_period(input int unsigned slot,
                                                 input int unsigned bck_div);
        return 2 * slot * bck_div;
    endfunction

endpackage

// File: rtl/i2s_xmit_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_xmit_clkgen
// Bit/frame clock generator for the I2S master.
//   mck            : master clock, all state on posedge
//   rst            : synchronous active-high reset
//   tick_o         : high in the mck cycle whose closing edge drops bck;
//                    every serial output advances on that edge
//   frame_start_o  : tick that moves the bit counter to position 0
//   chan_o         : channel of the bit position being entered on this tick
//   pos_o          : slot position (0..SLOT-1) being entered on this tick
//   bck_o          : registered bit clock, mck/BCK_DIV, 50% duty
//   lrck_o         : registered frame clock (0 = left, 1 = right)
// ---------------------------------------------------------------------------
module i2s_xmit_clkgen
    import i2s_xmit_pkg::*;
#(
    parameter  int SLOT    = I2S_SLOT,
    parameter  int BCK_DIV = I2S_BCK_DIV,
    localparam int BW      = $clog2(2 * SLOT),
    localparam int DW      = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1
) (
    input  logic          mck,
    input  logic          rst,
    output logic          tick_o,
    output logic          frame_start_o,
    output i2s_ch_e       chan_o,
    output logic [BW-1:0] pos_o,
    output logic          bck_o,
    output logic          lrck_o
);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bck_q, bck_d;
    logic          lrck_q, lrck_d;

    logic          tick;
    logic [BW-1:0] bit_next;
    i2s_ch_e       chan_next;
    logic [BW-1:0] pos_next;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);

        // Position the serial logic will be in after this tick. The bit
        // counter resets to its last value so the first tick lands on 0.
        bit_next  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
        chan_next = (bit_next >= SLOT_B) ? CH_RIGHT : CH_LEFT;
        pos_next  = (chan_next == CH_RIGHT) ? bit_next - SLOT_B : bit_next;

        bit_cnt_d = tick ? bit_next : bit_cnt_q;

        // bck rises mid-period and falls on the tick edge, so data launched
        // on the tick is stable across the following rising edge.
        bck_d = bck_q;
        if (div_cnt_q == DIV_HALF) begin
            bck_d = 1'b1;
        end else if (tick) begin
            bck_d = 1'b0;
        end

        lrck_d = tick ? logic'(chan_next) : lrck_q;
    end

    always_ff @(posedge mck) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BIT_LAST;
            bck_q     <= 1'b0;
            lrck_q    <= logic'(CH_LEFT);
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bck_q     <= bck_d;
            lrck_q    <= lrck_d;
        end
    end

    assign tick_o        = tick;
    assign frame_start_o = tick && (bit_next == '0);
    assign chan_o        = chan_next;
    assign pos_o         = pos_next;
    assign bck_o         = bck_q;
    assign lrck_o        = lrck_q;

endmodule

// File: rtl/i2s_xmit.sv
// ---------------------------------------------------------------------------
// i2s_xmit
// I2S master transmitter. Accepts left/right sample pairs through a
// valid/ready handshake into a one-deep holding buffer, latches the buffer
// into frame registers at each frame start and shifts standard I2S (MSB one
// bck after each lrck edge, data launched on bck falling edge).
//   mck        : master clock
//   rst        : synchronous active-high reset
//   l_data     : left sample, two's complement
//   r_data     : right sample, two's complement
//   data_valid : producer presents l_data/r_data
//   data_ready : holding buffer empty; pair taken when valid && ready
//   bck        : bit clock
//   lrck       : frame clock, 0 = left slot, 1 = right slot
//   data_out   : serial data, MSB first
//   underrun   : one-cycle pulse when a frame starts with an empty buffer
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module i2s_xmit
    import i2s_xmit_pkg::*;
#(
    parameter int WIDTH   = I2S_WIDTH,
    parameter int SLOT    = I2S_SLOT,
    parameter int BCK_DIV = I2S_BCK_DIV
) (
    input  logic             mck,
    input  logic             rst,
    input  logic [WIDTH-1:0] l_data,
    input  logic [WIDTH-1:0] r_data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bck,
    output logic             lrck,
    output logic             data_out,
    output logic             underrun
);

    localparam int BW = $clog2(2 * SLOT);

    // Clock generator strobes
    logic          tick;
    logic          frame_start;
    i2s_ch_e       chan;
    logic [BW-1:0] pos;

    // Holding buffer, frame registers and registered outputs
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d;
    logic [WIDTH-1:0] buf_r_q, buf_r_d;
    logic [WIDTH-1:0] frame_l_q, frame_l_d;
    logic [WIDTH-1:0] frame_r_q, frame_r_d;
    logic             ready_q, ready_d;
    logic             data_out_q, data_out_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic [WIDTH-1:0] slot_word;
    logic [WIDTH-1:0] bit_hit;

    i2s_xmit_clkgen #(
        .SLOT    (SLOT),
        .BCK_DIV (BCK_DIV)
    ) u_clkgen (
        .mck           (mck),
        .rst           (rst),
        .tick_o        (tick),
        .frame_start_o (frame_start),
        .chan_o        (chan),
        .pos_o         (pos),
        .bck_o         (bck),
        .lrck_o        (lrck)
    );

    assign accept    = data_valid && ready_q;
    assign slot_word = (chan == CH_RIGHT) ? frame_r_q : frame_l_q;

    // Slot position p (1..WIDTH) carries sample bit WIDTH-p. Each bit of the
    // active word owns one position; pad and tail positions match nothing
    // and therefore send 0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
        assign bit_hit[gi] = (pos == BW'(WIDTH - gi)) && slot_word[gi];
    end

    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        underrun_d = 1'b0;
        data_out_d = data_out_q;

        // Frame start looks only at the registered buffer state, so a pair
        // accepted on the same edge waits for the next frame.
        if (frame_start) begin
            if (buf_full_q) begin
                frame_l_d  = buf_l_q;
                frame_r_d  = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                frame_l_d  = '0;
                frame_r_d  = '0;
                underrun_d = 1'b1;
            end
        end

        // ready is only high while the buffer is empty, so an accept never
        // collides with a buffer-to-frame copy.
        if (accept) begin
            buf_l_d    = l_data;
            buf_r_d    = r_data;
            buf_full_d = 1'b1;
        end

        ready_d = !buf_full_d;

        // At frame start pos is 0 (pad bit), so reading the frame registers
        // before they reload is harmless.
        if (tick) begin
            data_out_d = |bit_hit;
        end
    end

    always_ff @(posedge mck) begin
        if (rst) begin
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            ready_q    <= 1'b0;
            data_out_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_ready = ready_q;
    assign data_out   = data_out_q;
    assign underrun   = underrun_q;

endmodule
